// File: rtl/fm_sb_pkg.sv
// fm_sb_pkg: shared types and constants for the fast-monitoring spy-buffer playback path
package fm_sb_pkg;

    localparam int pb_mode_width = 2;

    localparam logic [pb_mode_width-1:0] PB_MODE_OFF    = 2'b00;
    localparam logic [pb_mode_width-1:0] PB_MODE_SINGLE = 2'b01;
    localparam logic [pb_mode_width-1:0] PB_MODE_LOOP   = 2'b10;

    localparam int FM_PB_DEPTH = 1024;

    // One fast-monitoring stream word
    typedef struct packed {
        logic [7:0]  src;
        logic [7:0]  tag;
        logic [15:0] val;
    } fm_rt;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} fm_pb_state_t;

    // Only single-shot and loop start playback; off and the reserved code act as off
    function automatic logic pb_mode_active(input logic [pb_mode_width-1:0] m);
        return (m == PB_MODE_SINGLE) || (m == PB_MODE_LOOP);
    endfunction

endpackage

// File: rtl/fm_pb_player_if.sv
// fm_pb_player_if: control, memory-load, live-input and stream-output signals of the playback player
interface fm_pb_player_if #(
    parameter int DATA_W = $bits(fm_sb_pkg::fm_rt),
    parameter int ADDR_W = $clog2(fm_sb_pkg::FM_PB_DEPTH),
    parameter int GAP_W  = 8
);
    logic [fm_sb_pkg::pb_mode_width-1:0] playback_mode;
    logic                                pb_start;
    logic                                pb_stop;
    logic [ADDR_W:0]                     pb_len;
    logic [GAP_W-1:0]                    pb_gap;
    logic                                wr_en;
    logic [ADDR_W-1:0]                   wr_addr;
    logic [DATA_W-1:0]                   wr_data;
    logic                                err_clr;
    logic [DATA_W-1:0]                   live_data;
    logic                                live_valid;
    logic [DATA_W-1:0]                   out_data;
    logic                                out_valid;
    logic                                busy;
    logic                                done;
    logic [15:0]                         loop_cnt;
    logic                                wr_err;

    modport master (
        output playback_mode, pb_start, pb_stop, pb_len, pb_gap,
        output wr_en, wr_addr, wr_data, err_clr, live_data, live_valid,
        input  out_data, out_valid, busy, done, loop_cnt, wr_err
    );

    modport slave (
        input  playback_mode, pb_start, pb_stop, pb_len, pb_gap,
        input  wr_en, wr_addr, wr_data, err_clr, live_data, live_valid,
        output out_data, out_valid, busy, done, loop_cnt, wr_err
    );

endinterface

// File: rtl/fm_pb_ram.sv
// fm_pb_ram: simple dual-port RAM with registered read and write-first bypass on address match
module fm_pb_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              re,
    input  logic [ADDR_W-1:0] ra,
    output logic [DATA_W-1:0] rd
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port plus registered read; a same-edge write to the read address returns the new word
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        if (re) rd <= (we && wa == ra) ? wd : mem[ra];
    end

endmodule

// File: rtl/fm_pb_player.sv
// fm_pb_player: spy-buffer playback source that streams stored words or passes live data through
module fm_pb_player import fm_sb_pkg::*; #(
    parameter int DATA_W = $bits(fm_rt),
    parameter int DEPTH  = FM_PB_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int GAP_W  = 8
) (
    input logic           clk_hs,
    input logic           rst_hs,
    fm_pb_player_if.slave bus
);

    fm_pb_state_t      state_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [GAP_W-1:0]  gap_cnt_q;
    logic [GAP_W-1:0]  gap_q;
    logic [ADDR_W:0]   len_q;
    logic              loop_q;
    logic              drain_cnt_q;
    logic              normal_q;
    logic [15:0]       loop_cnt_q;
    logic [15:0]       loop_cnt_d;
    logic              done_q;
    logic              wr_err_q;
    logic              pb_v_q;
    logic              live_v_q;
    logic [DATA_W-1:0] live_d_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] ram_rd;

    logic              idle;
    logic              start;
    logic              abort;
    logic              issue;
    logic              last;
    logic              loop_e;
    logic              live_ok;
    logic [ADDR_W:0]   len_clamp;
    logic [ADDR_W:0]   len_e;
    logic [ADDR_W-1:0] addr_e;
    logic [GAP_W-1:0]  gap_e;
    logic [15:0]       loop_base;

    // Read-issue decision; the start cycle itself issues address 0 using the live settings
    always_comb begin
        idle       = state_q == IDLE;
        len_clamp  = (bus.pb_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : bus.pb_len;
        start      = idle && bus.pb_start && !bus.pb_stop && pb_mode_active(bus.playback_mode)
                     && bus.pb_len != '0;
        abort      = state_q == RUN && (bus.pb_stop || !pb_mode_active(bus.playback_mode));
        issue      = start || (state_q == RUN && !abort && gap_cnt_q == '0);
        len_e      = idle ? len_clamp : len_q;
        gap_e      = idle ? bus.pb_gap : gap_q;
        loop_e     = idle ? bus.playback_mode == PB_MODE_LOOP : loop_q;
        addr_e     = idle ? '0 : rd_addr_q;
        last       = {1'b0, addr_e} == len_e - (ADDR_W+1)'(1);
        loop_base  = start ? '0 : loop_cnt_q;
        loop_cnt_d = (issue && last && loop_e && loop_base != '1) ? loop_base + 16'd1 : loop_base;
        live_ok    = idle && !start;
    end

    fm_pb_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk(clk_hs),
        .we (bus.wr_en && idle),
        .wa (bus.wr_addr),
        .wd (bus.wr_data),
        .re (issue),
        .ra (addr_e),
        .rd (ram_rd)
    );

    // Playback FSM with address/gap counters, loop counter, done pulse and sticky write error
    always_ff @(posedge clk_hs or negedge rst_hs) begin
        if (!rst_hs) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            gap_cnt_q   <= '0;
            gap_q       <= '0;
            len_q       <= '0;
            loop_q      <= 1'b0;
            drain_cnt_q <= 1'b0;
            normal_q    <= 1'b0;
            loop_cnt_q  <= '0;
            done_q      <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE:    if (start) state_q <= (last && !loop_e) ? DRAIN : RUN;
                RUN:     if (abort || (issue && last && !loop_e)) state_q <= DRAIN;
                DRAIN:   if (drain_cnt_q) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (start) begin
                len_q  <= len_clamp;
                gap_q  <= bus.pb_gap;
                loop_q <= loop_e;
            end
            if (issue) begin
                rd_addr_q <= last ? '0 : addr_e + ADDR_W'(1);
                gap_cnt_q <= gap_e;
            end else if (gap_cnt_q != '0) begin
                gap_cnt_q <= gap_cnt_q - GAP_W'(1);
            end
            if (state_q != DRAIN) normal_q <= !abort;
            drain_cnt_q <= state_q == DRAIN && !drain_cnt_q;
            done_q      <= state_q == DRAIN && drain_cnt_q && normal_q;
            loop_cnt_q  <= loop_cnt_d;
            wr_err_q    <= (bus.wr_en && !idle) || (wr_err_q && !bus.err_clr);
        end
    end

    // Two-stage output path: live words only survive while idle, playback words take priority
    always_ff @(posedge clk_hs or negedge rst_hs) begin
        if (!rst_hs) begin
            pb_v_q      <= 1'b0;
            live_v_q    <= 1'b0;
            live_d_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            pb_v_q      <= issue;
            live_v_q    <= bus.live_valid && live_ok;
            if (bus.live_valid) live_d_q <= bus.live_data;
            out_valid_q <= pb_v_q || (live_v_q && live_ok);
            if (pb_v_q) out_data_q <= ram_rd;
            else if (live_v_q && live_ok) out_data_q <= live_d_q;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = !idle;
    assign bus.done      = done_q;
    assign bus.loop_cnt  = loop_cnt_q;
    assign bus.wr_err    = wr_err_q;

endmodule
